inst_fetch: RTL and testbench
=============================

# inst_fetch

Fetch initiator for the instruction register write handshake. On a fetch request from the control unit it reads one word from instruction memory at the current PC and delivers it to the instruction register via `ir_wr` / `ir_wr_ack`. After the acknowledge it advances the PC and reports completion. It sits between the control FSM, instruction memory and the instruction register.

## Interface
- `PA_DATA_WIDTH`, 32: instruction word width.
- `PA_ADDR_WIDTH`, 32: PC / memory address width.
- `PA_RESET_PC`, 0: PC value after reset.
- `PA_TIMEOUT`, 16: cycle limit for each wait (only used with `INST_FETCH_TIMEOUT_EN`).
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst_b` in 1: synchronous, active-high reset.
- `start` in 1: fetch request; sampled only in IDLE.
- `pc_load` in 1: load `pc_in` into the PC; honoured only in IDLE.
- `pc_in` in PA_ADDR_WIDTH: new PC value.
- `mem_addr` out PA_ADDR_WIDTH: memory read address.
- `mem_rd` out 1: memory read strobe, one-cycle pulse.
- `mem_rdata` in PA_DATA_WIDTH: memory read data.
- `mem_rvalid` in 1: `mem_rdata` is valid this cycle.
- `ir_data` out PA_DATA_WIDTH: word presented to the instruction register.
- `ir_wr` out 1: IR write request, one-cycle pulse.
- `ir_wr_ack` in 1: IR write acknowledge.
- `pc` out PA_ADDR_WIDTH: current PC.
- `busy` out 1: high in every state except IDLE.
- `fetch_done` out 1: one-cycle pulse when a fetch completes.
- `fetch_err` out 1: one-cycle pulse on timeout.

## Operation
- All outputs are registered.
- Reset values:
  - `pc` = PA_RESET_PC.
  - `mem_addr`, `ir_data` = 0.
  - `mem_rd`, `ir_wr`, `busy`, `fetch_done`, `fetch_err` = 0.
  - State = IDLE.
- States and transitions:
  - IDLE:
    - `pc_load` → `pc` = `pc_in`.
    - Otherwise, if `start` → MEM_RD.
    - `pc_load` and `start` in the same cycle: the load wins and `start` is dropped.
  - MEM_RD: `mem_rd` = 1, `mem_addr` = `pc`, for one cycle. If `mem_rvalid` → IR_WR, else → MEM_WAIT.
  - MEM_WAIT: on `mem_rvalid`, capture `mem_rdata` → IR_WR.
  - IR_WR: `ir_wr` = 1 for exactly one cycle, `ir_data` = captured word → IR_ACK.
  - IR_ACK:
    - `ir_data` is held stable.
    - On `ir_wr_ack`: `fetch_done` pulse, `pc` ← `pc` + 4 (modulo 2^PA_ADDR_WIDTH, so 0xFFFFFFFC wraps to 0) → IDLE.
- `ir_wr` is never held for more than one cycle. The IR samples the request again in its idle state, so a held request would cause a double write.
- Ignored inputs:
  - `start` and `pc_load` outside IDLE.
  - `mem_rvalid` outside MEM_RD/MEM_WAIT.
  - `ir_wr_ack` outside IR_ACK (stray acks).
- Reset in any state forces the reset values on the next edge; any in-flight memory or IR response arriving afterwards is ignored.

## Timing
- `start` high in IDLE at cycle N → `mem_rd` high at N+1.
- `mem_rvalid` sampled at cycle M → `ir_wr` high at M+1, low at M+2.
- `ir_wr_ack` sampled at cycle K → `fetch_done` high and `pc` updated at K+1; `busy` low at K+1.
- With a zero-wait memory and the standard IR (ack three cycles after the request):
  - `start` at N, `mem_rvalid` at N+1 → `ir_wr` at N+2, `ir_wr_ack` at N+5, `fetch_done` at N+6.
- Back-to-back: `start` held high → the next `mem_rd` is at K+2.

## Configuration
- `INST_FETCH_TIMEOUT_EN` defined:
  - A counter clears on entry to MEM_WAIT or IR_ACK and increments every cycle spent there.
  - At count == PA_TIMEOUT-1 without the awaited input: `fetch_err` pulse next cycle → IDLE, `pc` unchanged.
- Undefined:
  - No counter; the block waits indefinitely.
  - `fetch_err` is tied to 0.

## Structure
- Shared package:
  - State encoding constants: IDLE, MEM_RD, MEM_WAIT, IR_WR, IR_ACK, 3-bit.
  - PC increment constant 4.
  - Width defaults.
- One sub-module, `fetch_timer`: a loadable up-counter with a terminal-count output, instantiated only under `INST_FETCH_TIMEOUT_EN`.

## Test plan
- Reset, then idle for 5 cycles → `pc` = 0; `mem_rd`, `ir_wr`, `busy`, `fetch_done`, `fetch_err` all 0.
- `start`; memory returns 0xDEADBEEF 2 cycles after `mem_rd`; IR model acks 3 cycles after `ir_wr` → `mem_addr` = 0, single-cycle `ir_wr` with `ir_data` = 0xDEADBEEF, one `fetch_done`, `pc` = 4.
- `pc_load` 0xFFFFFFFC, then fetch → `mem_addr` = 0xFFFFFFFC, `pc` = 0 after `fetch_done`.
- With the timeout enabled (PA_TIMEOUT = 8) and the IR never acking → `fetch_err` pulse 8 cycles after entering IR_ACK, `pc` unchanged, no `fetch_done`.
- `start` / `pc_load` pulsed during IR_ACK and a stray `ir_wr_ack` in IDLE → no effect on `pc`, no extra `mem_rd` or `fetch_done`.
- `rst_b` asserted in IR_ACK, then a late `ir_wr_ack` → all outputs at reset values next cycle, `pc` = PA_RESET_PC, no `fetch_done`.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch initiator.
// Optional timeout support is enabled with INST_FETCH_TIMEOUT_EN.
package inst_fetch_pkg;

    localparam int unsigned DefaultDataWidth = 32;
    localparam int unsigned DefaultAddrWidth = 32;
    localparam int unsigned DefaultTimeout   = 16;
    localparam int unsigned PcIncrement      = 4;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StMemRd   = 3'd1,
        StMemWait = 3'd2,
        StIrWr    = 3'd3,
        StIrAck   = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_timer.sv
// Up-counter cleared by load, with a terminal-count flag at LIMIT-1.
// Only instantiated by inst_fetch when INST_FETCH_TIMEOUT_EN is defined.
module fetch_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_b,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/inst_fetch.sv
// Fetch initiator: reads one word at PC, hands it to the IR, then advances PC.
// Define INST_FETCH_TIMEOUT_EN to bound the memory and IR-ack waits by PA_TIMEOUT cycles.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned                PA_DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned                PA_ADDR_WIDTH = DefaultAddrWidth,
    parameter logic [PA_ADDR_WIDTH-1:0]   PA_RESET_PC   = '0,
    parameter int unsigned                PA_TIMEOUT    = DefaultTimeout
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     start,
    input  logic                     pc_load,
    input  logic [PA_ADDR_WIDTH-1:0] pc_in,
    output logic [PA_ADDR_WIDTH-1:0] mem_addr,
    output logic                     mem_rd,
    input  logic [PA_DATA_WIDTH-1:0] mem_rdata,
    input  logic                     mem_rvalid,
    output logic [PA_DATA_WIDTH-1:0] ir_data,
    output logic                     ir_wr,
    input  logic                     ir_wr_ack,
    output logic [PA_ADDR_WIDTH-1:0] pc,
    output logic                     busy,
    output logic                     fetch_done,
    output logic                     fetch_err
);

    fetch_state_e state;

`ifdef INST_FETCH_TIMEOUT_EN
    logic timer_load;
    logic timer_en;
    logic timer_tc;

    // Clear on the edge that enters a wait state so the count starts at 0 there.
    assign timer_load = ((state == StMemRd) && !mem_rvalid) || (state == StIrWr);
    assign timer_en   = (state == StMemWait) || (state == StIrAck);

    fetch_timer #(
        .LIMIT (PA_TIMEOUT)
    ) u_fetch_timer (
        .clk   (clk),
        .rst_b (rst_b),
        .load  (timer_load),
        .en    (timer_en),
        .tc    (timer_tc)
    );
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state      <= StIdle;
            pc         <= PA_RESET_PC;
            mem_addr   <= '0;
            ir_data    <= '0;
            mem_rd     <= 1'b0;
            ir_wr      <= 1'b0;
            busy       <= 1'b0;
            fetch_done <= 1'b0;
`ifdef INST_FETCH_TIMEOUT_EN
            fetch_err  <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle; a held ir_wr would be taken as a second write.
            mem_rd     <= 1'b0;
            ir_wr      <= 1'b0;
            fetch_done <= 1'b0;
`ifdef INST_FETCH_TIMEOUT_EN
            fetch_err  <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    if (pc_load) begin
                        pc <= pc_in;
                    end else if (start) begin
                        state    <= StMemRd;
                        mem_rd   <= 1'b1;
                        mem_addr <= pc;
                        busy     <= 1'b1;
                    end
                end
                StMemRd: begin
                    if (mem_rvalid) begin
                        ir_data <= mem_rdata;
                        ir_wr   <= 1'b1;
                        state   <= StIrWr;
                    end else begin
                        state <= StMemWait;
                    end
                end
                StMemWait: begin
                    if (mem_rvalid) begin
                        ir_data <= mem_rdata;
                        ir_wr   <= 1'b1;
                        state   <= StIrWr;
                    end
`ifdef INST_FETCH_TIMEOUT_EN
                    else if (timer_tc) begin
                        fetch_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
`endif
                end
                StIrWr: begin
                    state <= StIrAck;
                end
                StIrAck: begin
                    if (ir_wr_ack) begin
                        fetch_done <= 1'b1;
                        pc         <= pc + PA_ADDR_WIDTH'(PcIncrement);
                        busy       <= 1'b0;
                        state      <= StIdle;
                    end
`ifdef INST_FETCH_TIMEOUT_EN
                    else if (timer_tc) begin
                        fetch_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
`endif
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized self-checking bench for inst_fetch with behavioural memory and IR responders.
// Builds with or without INST_FETCH_TIMEOUT_EN.
module tb_inst_fetch;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          start;
    logic          pc_load;
    logic [AW-1:0] pc_in;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic [DW-1:0] ir_data;
    logic          ir_wr;
    logic          ir_wr_ack;
    logic [AW-1:0] pc;
    logic          busy;
    logic          fetch_done;
    logic          fetch_err;

    logic ack_m = 1'b0;
    logic ack_stray;
    assign ir_wr_ack = ack_m | ack_stray;

    inst_fetch #(
        .PA_DATA_WIDTH (DW),
        .PA_ADDR_WIDTH (AW),
        .PA_RESET_PC   ('0),
        .PA_TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .start      (start),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .ir_data    (ir_data),
        .ir_wr      (ir_wr),
        .ir_wr_ack  (ir_wr_ack),
        .pc         (pc),
        .busy       (busy),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Responder configuration and observation record.
    logic [DW-1:0] mem_word = '0;
    int mem_lat = 0, ack_dly = 3, mem_cnt = -1, ack_cnt = -1;
    bit ack_en = 1'b1;
    int n_mem_rd = 0, n_ir_wr = 0, n_done = 0, n_err = 0, n_ir_double = 0;
    int rd_cyc = 0, rv_cyc = 0, wr_cyc = 0, ack_cyc = 0, done_cyc = 0, err_cyc = 0;
    logic [AW-1:0] last_mem_addr = '0;
    logic [DW-1:0] last_ir_data = '0;
    logic prev_ir_wr = 1'b0;

    logic [AW-1:0] exp_pc = '0;

    always @(negedge clk) begin
        if (mem_rd === 1'b1) begin
            n_mem_rd++; rd_cyc = cyc; last_mem_addr = mem_addr; mem_cnt = mem_lat;
        end
        if (ir_wr === 1'b1) begin
            n_ir_wr++; wr_cyc = cyc; last_ir_data = ir_data; ack_cnt = ack_dly;
            if (prev_ir_wr === 1'b1) n_ir_double++;
        end
        prev_ir_wr = ir_wr;
        if (fetch_done === 1'b1) begin n_done++; done_cyc = cyc; end
        if (fetch_err === 1'b1) begin n_err++; err_cyc = cyc; end
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        ack_m      = 1'b0;
        if (mem_cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = mem_word; rv_cyc = cyc; end
        if (mem_cnt >= 0) mem_cnt--;
        if (ack_cnt == 0 && ack_en) begin ack_m = 1'b1; ack_cyc = cyc; end
        if (ack_cnt >= 0) ack_cnt--;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_fetch(input logic [DW-1:0] word, input int lat, input int dly,
                             output bit ok, output int start_cyc);
        int base = n_done;
        mem_word = word; mem_lat = lat; ack_dly = dly;
        start = 1'b1; start_cyc = cyc;
        step();
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (n_done > base) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b1; start = 1'b0; pc_load = 1'b0; pc_in = '0; ack_stray = 1'b0;
        step(); step();
        rst_b = 1'b0;
        for (int i = 0; i < 5; i++) step();
        exp_pc = '0;
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, exp_pc); end
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
        n_checks++; if (ir_wr !== 1'b0) begin n_fail++; $display("FAIL reset_ir_wr: got %b want 0", ir_wr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (fetch_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", fetch_done); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fetch_err); end
        n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_checks++; if (ir_data !== '0) begin n_fail++; $display("FAIL reset_ir_data: got %h want 0", ir_data); end
    endtask

    task automatic test_basic_fetch();
        bit ok; int sc;
        int b_rd = n_mem_rd, b_wr = n_ir_wr, b_done = n_done;
        logic [AW-1:0] a = exp_pc;
        run_fetch(32'hDEADBEEF, 2, 3, ok, sc);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_done_seen: got 0 want 1"); end
        n_checks++; if (last_mem_addr !== a) begin n_fail++; $display("FAIL basic_mem_addr: got %h want %h", last_mem_addr, a); end
        n_checks++; if (n_mem_rd != b_rd + 1) begin n_fail++; $display("FAIL basic_mem_rd_cnt: got %0d want %0d", n_mem_rd - b_rd, 1); end
        n_checks++; if (n_ir_wr != b_wr + 1) begin n_fail++; $display("FAIL basic_ir_wr_cnt: got %0d want %0d", n_ir_wr - b_wr, 1); end
        n_checks++; if (last_ir_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_ir_data: got %h want deadbeef", last_ir_data); end
        n_checks++; if (ir_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_ir_data_held: got %h want deadbeef", ir_data); end
        n_checks++; if (n_done != b_done + 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d want 1", n_done - b_done); end
        n_checks++; if (wr_cyc != rv_cyc + 1) begin n_fail++; $display("FAIL basic_ir_wr_lat: got %0d want 1", wr_cyc - rv_cyc); end
        n_checks++; if (done_cyc != ack_cyc + 1) begin n_fail++; $display("FAIL basic_done_lat: got %0d want 1", done_cyc - ack_cyc); end
        exp_pc = a + 32'd4;
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL basic_pc: got %h want %h", pc, exp_pc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_low: got %b want 0", busy); end
        step();
        n_checks++; if (fetch_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", fetch_done); end
    endtask

    task automatic test_zero_wait_timing();
        bit ok; int sc;
        run_fetch($urandom, 0, 3, ok, sc);
        exp_pc = exp_pc + 32'd4;
        n_checks++; if (rd_cyc != sc + 1) begin n_fail++; $display("FAIL zw_mem_rd_cyc: got %0d want %0d", rd_cyc - sc, 1); end
        n_checks++; if (wr_cyc != sc + 2) begin n_fail++; $display("FAIL zw_ir_wr_cyc: got %0d want %0d", wr_cyc - sc, 2); end
        n_checks++; if (done_cyc != sc + 6) begin n_fail++; $display("FAIL zw_done_cyc: got %0d want %0d", done_cyc - sc, 6); end
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL zw_pc: got %h want %h", pc, exp_pc); end
    endtask

    task automatic test_wrap();
        bit ok; int sc;
        pc_load = 1'b1; pc_in = 32'hFFFF_FFFC;
        step();
        pc_load = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL wrap_load: got %h want %h", pc, exp_pc); end
        run_fetch($urandom, 1, 2, ok, sc);
        n_checks++; if (last_mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_mem_addr: got %h want fffffffc", last_mem_addr); end
        exp_pc = exp_pc + 32'd4;
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", pc, exp_pc); end
    endtask

    task automatic test_load_priority();
        int b_rd = n_mem_rd;
        logic [AW-1:0] v = $urandom & 32'hFFFF_FFFC;
        pc_load = 1'b1; start = 1'b1; pc_in = v;
        step();
        pc_load = 1'b0; start = 1'b0;
        step(); step();
        exp_pc = v;
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL prio_pc: got %h want %h", pc, exp_pc); end
        n_checks++; if (n_mem_rd != b_rd) begin n_fail++; $display("FAIL prio_no_rd: got %0d want 0", n_mem_rd - b_rd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_busy: got %b want 0", busy); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            bit ok; int sc;
            logic [DW-1:0] w = $urandom;
            logic [AW-1:0] a;
            if ($urandom_range(0, 3) == 0) begin
                pc_load = 1'b1; pc_in = $urandom & 32'hFFFF_FFFC;
                step();
                pc_load = 1'b0; exp_pc = pc_in;
            end
            a = exp_pc;
            run_fetch(w, $urandom_range(0, 4), $urandom_range(1, 5), ok, sc);
            exp_pc = a + 32'd4;
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd_done[%0d]: got 0 want 1", it); end
            n_checks++; if (last_mem_addr !== a) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", it, last_mem_addr, a); end
            n_checks++; if (last_ir_data !== w) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", it, last_ir_data, w); end
            n_checks++; if (wr_cyc != rv_cyc + 1) begin n_fail++; $display("FAIL rnd_wr_lat[%0d]: got %0d want 1", it, wr_cyc - rv_cyc); end
            n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", it, pc, exp_pc); end
        end
    endtask

    task automatic test_back_to_back();
        int b_rd = n_mem_rd, b_done = n_done;
        int d1 = 0;
        bit seen = 1'b0;
        logic [DW-1:0] w2 = $urandom;
        logic [AW-1:0] a = exp_pc;
        mem_word = $urandom; mem_lat = 0; ack_dly = 3;
        start = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            if (n_done > b_done) seen = 1'b1;
        end
        d1 = done_cyc;
        mem_word = w2;
        step();
        start = 1'b0;
        n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_first_done: got 0 want 1"); end
        n_checks++; if (n_mem_rd != b_rd + 2 || rd_cyc != d1 + 1) begin
            n_fail++; $display("FAIL b2b_next_rd: got rd=%0d at +%0d want rd=2 at +1", n_mem_rd - b_rd, rd_cyc - d1);
        end
        for (int i = 0; i < 50 && n_done < b_done + 2; i++) step();
        exp_pc = a + 32'd8;
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL b2b_pc: got %h want %h", pc, exp_pc); end
        n_checks++; if (last_mem_addr !== a + 32'd4) begin n_fail++; $display("FAIL b2b_addr2: got %h want %h", last_mem_addr, a + 32'd4); end
        n_checks++; if (last_ir_data !== w2) begin n_fail++; $display("FAIL b2b_data2: got %h want %h", last_ir_data, w2); end
        step(); step();
        n_checks++; if (n_mem_rd != b_rd + 2) begin n_fail++; $display("FAIL b2b_rd_total: got %0d want 2", n_mem_rd - b_rd); end
    endtask

    task automatic test_ignored_inputs();
        int b_rd = n_mem_rd, b_wr = n_ir_wr, b_done = n_done;
        logic [AW-1:0] a = exp_pc;
        mem_word = $urandom; mem_lat = 1; ack_dly = 6;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && n_ir_wr == b_wr; i++) step();
        step();
        start = 1'b1; pc_load = 1'b1; pc_in = $urandom;
        step();
        start = 1'b0; pc_load = 1'b0;
        for (int i = 0; i < 20 && n_done == b_done; i++) step();
        exp_pc = a + 32'd4;
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL ign_pc: got %h want %h", pc, exp_pc); end
        n_checks++; if (n_mem_rd != b_rd + 1) begin n_fail++; $display("FAIL ign_rd_cnt: got %0d want 1", n_mem_rd - b_rd); end
        step();
        ack_stray = 1'b1;
        step();
        ack_stray = 1'b0;
        step(); step(); step();
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL stray_pc: got %h want %h", pc, exp_pc); end
        n_checks++; if (n_done != b_done + 1) begin n_fail++; $display("FAIL stray_done_cnt: got %0d want 1", n_done - b_done); end
        n_checks++; if (n_mem_rd != b_rd + 1) begin n_fail++; $display("FAIL stray_rd_cnt: got %0d want 1", n_mem_rd - b_rd); end
    endtask

`ifdef INST_FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int b_wr = n_ir_wr, b_err = n_err, b_done = n_done;
        mem_word = $urandom; mem_lat = 0; ack_dly = 2; ack_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && n_err == b_err; i++) step();
        n_checks++; if (n_err != b_err + 1) begin n_fail++; $display("FAIL to_err_cnt: got %0d want 1", n_err - b_err); end
        n_checks++; if (n_ir_wr != b_wr + 1 || err_cyc != wr_cyc + 1 + int'(TO)) begin
            n_fail++; $display("FAIL to_err_cyc: got +%0d want +%0d", err_cyc - wr_cyc - 1, TO);
        end
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL to_pc: got %h want %h", pc, exp_pc); end
        n_checks++; if (n_done != b_done) begin n_fail++; $display("FAIL to_no_done: got %0d want 0", n_done - b_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b want 0", busy); end
        step();
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse: got %b want 0", fetch_err); end
        ack_en = 1'b1;
    endtask
`else
    task automatic test_no_err();
        n_checks++; if (n_err != 0) begin n_fail++; $display("FAIL no_err: got %0d want 0", n_err); end
    endtask
`endif

    task automatic test_reset_in_ack();
        int b_wr = n_ir_wr, b_done = n_done;
        mem_word = $urandom; mem_lat = 0; ack_dly = 4;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && n_ir_wr == b_wr; i++) step();
        step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        exp_pc = '0;
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc, exp_pc); end
        n_checks++; if ({mem_rd, ir_wr, busy, fetch_done, fetch_err} !== 5'b0) begin
            n_fail++; $display("FAIL rst_flags: got %b want 00000", {mem_rd, ir_wr, busy, fetch_done, fetch_err});
        end
        n_checks++; if (mem_addr !== '0 || ir_data !== '0) begin
            n_fail++; $display("FAIL rst_data: got %h/%h want 0/0", mem_addr, ir_data);
        end
        for (int i = 0; i < 6; i++) step();
        n_checks++; if (n_done != b_done) begin n_fail++; $display("FAIL rst_late_ack: got %0d want 0", n_done - b_done); end
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rst_late_pc: got %h want %h", pc, exp_pc); end
        n_checks++; if (n_ir_double != 0) begin n_fail++; $display("FAIL ir_wr_single: got %0d want 0", n_ir_double); end
    endtask

    initial begin
        rst_b = 1'b1; start = 1'b0; pc_load = 1'b0; pc_in = '0; ack_stray = 1'b0;
        test_reset();
        test_basic_fetch();
        test_zero_wait_timing();
        test_wrap();
        test_load_priority();
        test_random();
        test_back_to_back();
        test_ignored_inputs();
`ifdef INST_FETCH_TIMEOUT_EN
        test_timeout();
`else
        test_no_err();
`endif
        test_reset_in_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
